// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package riscv_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters with anti-starvation counter.
module mem_arb_prio
  import riscv_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       grant,
  output arb_owner_t winner_c
);

  localparam int unsigned SC_W = cnt_width(STARVE_MAX);

  logic [SC_W-1:0] starve_cnt;
  logic            starved_c;

  // Data is older in the pipeline, so it wins unless fetch has waited too long.
  assign starved_c = (starve_cnt == SC_W'(STARVE_MAX));
  assign winner_c  = (if_req && (!dm_req || starved_c)) ? OWN_IF : OWN_DM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (winner_c == OWN_IF) begin
        starve_cnt <= '0;
      end else if (if_req && !starved_c) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported fixed-latency memory arbiter between instruction fetch and
// MEM-stage data accesses; one access in flight, done pulse to the winner.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_done,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = cnt_width(MEM_LAT - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  arb_owner_t       owner;
  arb_owner_t       winner_c;
  logic             lat_we;
  logic             grant_c;

  assign grant_c = (state == IDLE) && (if_req || dm_req);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant    (grant_c),
    .winner_c (winner_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: GRANT issues the strobe, WAIT covers the remaining latency.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_c) state_nxt = GRANT;
      end
      GRANT: begin
        if (MEM_LAT == 1) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Access fields are captured at grant and held until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_IF;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant_c) begin
      owner <= winner_c;
      if (winner_c == OWN_IF) begin
        lat_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= {BE_W{1'b1}};
      end else begin
        lat_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end
    end
  end

  assign mem_en    = (state == GRANT);
  assign mem_we    = mem_en && (owner == OWN_DM) && lat_we;
  assign if_done   = (state == DONE) && (owner == OWN_IF);
  assign dm_done   = (state == DONE) && (owner == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign stall_if  = if_req && !if_done;
  assign stall_mem = dm_req && !dm_done;

endmodule
